// File: rtl/system_0_sysid_check_ctrl.sv
// Reads the sysid slave (word 0 = ID, word 1 = timestamp), compares both against build-time values
// and reports pass/fail. Optional interrupt on failure when SYSID_CHECK_IRQ_EN is defined.
module system_0_sysid_check_ctrl #(
   parameter logic [31:0] EXP_ID     = 32'd0,
   parameter logic [31:0] EXP_TS     = 32'd1563219222,
   parameter int unsigned SAMPLE_DLY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        sysid_address,
   input  logic [31:0] sysid_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
`ifdef SYSID_CHECK_IRQ_EN
   ,
   output logic        irq,
   input  logic        irq_ack
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_ID = 2'd1,
      RD_TS = 2'd2,
      CMP   = 2'd3
   } state_t;

   // Count value on which readdata is sampled; SAMPLE_DLY is legal in 1..15.
   localparam logic [3:0] CNT_LAST = 4'(SAMPLE_DLY - 1);

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic        addr_n, busy_n, done_n, pass_n, fail_n;
   logic [31:0] id_n, ts_n;
   logic        sample, match;

   assign sample = (cnt == CNT_LAST);
   assign match  = (id_value == EXP_ID) && (ts_value == EXP_TS);

   always_comb begin
      // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
      state_n = state;
      cnt_n   = cnt;
      addr_n  = sysid_address;
      busy_n  = busy;
      done_n  = 1'b0;
      pass_n  = pass;
      fail_n  = fail;
      id_n    = id_value;
      ts_n    = ts_value;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = RD_ID;
               addr_n  = 1'b0;
               cnt_n   = 4'd0;
               busy_n  = 1'b1;
               pass_n  = 1'b0;
               fail_n  = 1'b0;
            end
         end
         RD_ID: begin
            if (sample) begin
               id_n    = sysid_readdata;
               addr_n  = 1'b1;
               cnt_n   = 4'd0;
               state_n = RD_TS;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         RD_TS: begin
            if (sample) begin
               ts_n    = sysid_readdata;
               addr_n  = 1'b0;
               cnt_n   = 4'd0;
               state_n = CMP;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         CMP: begin
            pass_n  = match;
            fail_n  = ~match;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= 4'd0;
         sysid_address <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         fail          <= 1'b0;
         id_value      <= 32'd0;
         ts_value      <= 32'd0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         sysid_address <= addr_n;
         busy          <= busy_n;
         done          <= done_n;
         pass          <= pass_n;
         fail          <= fail_n;
         id_value      <= id_n;
         ts_value      <= ts_n;
      end
   end

`ifdef SYSID_CHECK_IRQ_EN
   // A failing compare wins over a simultaneous acknowledge.
   always_ff @(posedge clock) begin
      if (reset) begin
         irq <= 1'b0;
      end else if ((state == CMP) && !match) begin
         irq <= 1'b1;
      end else if (irq_ack) begin
         irq <= 1'b0;
      end
   end
`endif

endmodule
